// File: rtl/gerenciador_caminho_param_pkg.sv
// Shared definitions for the predecessor-memory path manager.
package gerenciador_caminho_param_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LIMPAR = 3'd1,
        ST_LER    = 3'd2,
        ST_ESPERA = 3'd3,
        ST_EMITIR = 3'd4,
        ST_FIM    = 3'd5
    } estado_e;

    localparam logic [1:0] ERRO_OK           = 2'd0;
    localparam logic [1:0] ERRO_INALCANCAVEL = 2'd1;
    localparam logic [1:0] ERRO_LONGO        = 2'd2;

    // Ceiling log2; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned valor);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((33'(1) << i) < 33'(valor)) r = 32'(i + 1);
        end
        return r;
    endfunction

endpackage

// File: rtl/gerenciador_caminho_param_ram.sv
// Simple dual-port RAM: one write port, one synchronous read port (1-cycle latency).
module dual_port_ram #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we_in,
    input  logic [ADDR_WIDTH-1:0] waddr_in,
    input  logic [DATA_WIDTH-1:0] wdata_in,
    input  logic [ADDR_WIDTH-1:0] raddr_in,
    output logic [DATA_WIDTH-1:0] rdata_out
);

    logic [DATA_WIDTH-1:0] mem_q [0:2**ADDR_WIDTH-1];

    always_ff @(posedge clk) begin
        if (we_in) mem_q[waddr_in] <= wdata_in;
        rdata_out <= mem_q[raddr_in];
    end

endmodule

// File: rtl/gerenciador_caminho_param.sv
// Stores solver predecessors and streams the destination->source path on request,
// with bulk clear, status reporting, backpressure and length/unreachable guards.
module gerenciador_caminho_param
    import gerenciador_caminho_param_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH   = 10,
    parameter int unsigned           MAX_PATH_LEN = 2**ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] INVALID_NODE = {ADDR_WIDTH{1'b1}}
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   write_en_in,
    input  logic [ADDR_WIDTH-1:0]                  write_addr_in,
    input  logic [ADDR_WIDTH-1:0]                  write_data_in,
    input  logic                                   limpar_in,
    input  logic                                   iniciar_in,
    input  logic [ADDR_WIDTH-1:0]                  top_fonte_in,
    input  logic [ADDR_WIDTH-1:0]                  top_destino_in,
    output logic [ADDR_WIDTH-1:0]                  caminho_data_out,
    output logic                                   caminho_valid_out,
    output logic                                   caminho_last_out,
    input  logic                                   caminho_ready_in,
    output logic                                   busy_out,
    output logic                                   pronto_out,
    output logic [1:0]                             erro_out,
    output logic [clog2(MAX_PATH_LEN+1)-1:0]       comprimento_out
);

    localparam int unsigned AW = ADDR_WIDTH;
    localparam int unsigned CW = clog2(MAX_PATH_LEN + 1);

    estado_e       state_q, state_d;
    logic [AW-1:0] cur_q, cur_d, fonte_q, fonte_d, pred_q, pred_d;
    logic [AW-1:0] sweep_q, sweep_d, data_q, data_d;
    logic [CW-1:0] contador_q, contador_d, comp_q, comp_d;
    logic          valid_q, valid_d, last_q, last_d;
    logic          busy_q, busy_d, pronto_q, pronto_d;
    logic [1:0]    erro_q, erro_d;

    logic          ram_we_c;
    logic [AW-1:0] ram_waddr_c, ram_wdata_c, ram_rdata;

    // Write port belongs to the solver in IDLE and to the clear sweep in LIMPAR.
    assign ram_we_c    = (state_q == ST_LIMPAR) || ((state_q == ST_IDLE) && write_en_in);
    assign ram_waddr_c = (state_q == ST_LIMPAR) ? sweep_q : write_addr_in;
    assign ram_wdata_c = (state_q == ST_LIMPAR) ? INVALID_NODE : write_data_in;

    dual_port_ram #(
        .DATA_WIDTH (AW),
        .ADDR_WIDTH (AW)
    ) u_ram (
        .clk       (clk),
        .we_in     (ram_we_c),
        .waddr_in  (ram_waddr_c),
        .wdata_in  (ram_wdata_c),
        .raddr_in  (cur_q),
        .rdata_out (ram_rdata)
    );

    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        fonte_d    = fonte_q;
        pred_d     = pred_q;
        sweep_d    = sweep_q;
        data_d     = data_q;
        contador_d = contador_q;
        comp_d     = comp_q;
        valid_d    = valid_q;
        last_d     = last_q;
        erro_d     = erro_q;
        pronto_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (limpar_in) begin
                    sweep_d = '0;
                    erro_d  = ERRO_OK;
                    comp_d  = '0;
                    state_d = ST_LIMPAR;
                end else if (iniciar_in) begin
                    fonte_d    = top_fonte_in;
                    cur_d      = top_destino_in;
                    contador_d = '0;
                    erro_d     = ERRO_OK;
                    comp_d     = '0;
                    state_d    = ST_LER;
                end
            end
            ST_LIMPAR: begin
                if (sweep_q == {AW{1'b1}}) begin
                    erro_d   = ERRO_OK;
                    pronto_d = 1'b1;
                    state_d  = ST_FIM;
                end else begin
                    sweep_d = sweep_q + AW'(1);
                end
            end
            ST_LER: state_d = ST_ESPERA;
            ST_ESPERA: begin
                pred_d  = ram_rdata;
                valid_d = 1'b1;
                data_d  = cur_q;
                last_d  = (cur_q == fonte_q);
                state_d = ST_EMITIR;
            end
            ST_EMITIR: begin
                if (caminho_ready_in) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    if (comp_q != CW'(MAX_PATH_LEN)) comp_d = comp_q + CW'(1);
                    if (cur_q == fonte_q) begin
                        erro_d   = ERRO_OK;
                        pronto_d = 1'b1;
                        state_d  = ST_FIM;
                    end else if (pred_q == INVALID_NODE) begin
                        erro_d   = ERRO_INALCANCAVEL;
                        pronto_d = 1'b1;
                        state_d  = ST_FIM;
                    end else if (contador_q == CW'(MAX_PATH_LEN - 1)) begin
                        erro_d   = ERRO_LONGO;
                        pronto_d = 1'b1;
                        state_d  = ST_FIM;
                    end else begin
                        cur_d      = pred_q;
                        contador_d = contador_q + CW'(1);
                        state_d    = ST_LER;
                    end
                end
            end
            ST_FIM:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cur_q      <= '0;
            fonte_q    <= '0;
            pred_q     <= '0;
            sweep_q    <= '0;
            data_q     <= '0;
            contador_q <= '0;
            comp_q     <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            busy_q     <= 1'b0;
            pronto_q   <= 1'b0;
            erro_q     <= ERRO_OK;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            fonte_q    <= fonte_d;
            pred_q     <= pred_d;
            sweep_q    <= sweep_d;
            data_q     <= data_d;
            contador_q <= contador_d;
            comp_q     <= comp_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            busy_q     <= busy_d;
            pronto_q   <= pronto_d;
            erro_q     <= erro_d;
        end
    end

    assign caminho_data_out  = data_q;
    assign caminho_valid_out = valid_q;
    assign caminho_last_out  = last_q;
    assign busy_out          = busy_q;
    assign pronto_out        = pronto_q;
    assign erro_out          = erro_q;
    assign comprimento_out   = comp_q;

endmodule

// File: tb/tb_gerenciador_caminho_param.sv
// Directed bench for gerenciador_caminho_param (ADDR_WIDTH=4, MAX_PATH_LEN=4).
module tb_gerenciador_caminho_param;
    import gerenciador_caminho_param_pkg::*;

    localparam int unsigned AW   = 4;
    localparam int unsigned MAXL = 4;
    localparam int unsigned CW   = clog2(MAXL + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          write_en_in = 1'b0;
    logic [AW-1:0] write_addr_in = '0;
    logic [AW-1:0] write_data_in = '0;
    logic          limpar_in = 1'b0;
    logic          iniciar_in = 1'b0;
    logic [AW-1:0] top_fonte_in = '0;
    logic [AW-1:0] top_destino_in = '0;
    logic [AW-1:0] caminho_data_out;
    logic          caminho_valid_out;
    logic          caminho_last_out;
    logic          caminho_ready_in = 1'b0;
    logic          busy_out;
    logic          pronto_out;
    logic [1:0]    erro_out;
    logic [CW-1:0] comprimento_out;

    gerenciador_caminho_param #(
        .ADDR_WIDTH   (AW),
        .MAX_PATH_LEN (MAXL)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .write_en_in       (write_en_in),
        .write_addr_in     (write_addr_in),
        .write_data_in     (write_data_in),
        .limpar_in         (limpar_in),
        .iniciar_in        (iniciar_in),
        .top_fonte_in      (top_fonte_in),
        .top_destino_in    (top_destino_in),
        .caminho_data_out  (caminho_data_out),
        .caminho_valid_out (caminho_valid_out),
        .caminho_last_out  (caminho_last_out),
        .caminho_ready_in  (caminho_ready_in),
        .busy_out          (busy_out),
        .pronto_out        (pronto_out),
        .erro_out          (erro_out),
        .comprimento_out   (comprimento_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [AW-1:0] got_data [16];
    logic          got_last [16];
    int            got_n, pronto_cnt, stab_err;
    bit            timed_out;
    logic [1:0]    fin_erro;
    logic [CW-1:0] fin_comp;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_pred(input logic [AW-1:0] a, input logic [AW-1:0] d);
        write_en_in = 1'b1; write_addr_in = a; write_data_in = d;
        tick();
        write_en_in = 1'b0;
    endtask

    task automatic do_clear();
        bit seen;
        seen = 1'b0;
        limpar_in = 1'b1;
        tick();
        limpar_in = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            if (pronto_out) seen = 1'b1;
            tick();
        end
        checks++;
        if (seen !== 1'b1) begin
            failures++;
            $display("FAIL clear_done: pronto seen=%0b required=1", seen);
        end
    endtask

    // Starts a run and records every accepted node until the pronto pulse.
    task automatic run_path(input logic [AW-1:0] f, input logic [AW-1:0] d, input bit toggle);
        bit [3:0]      pat;
        bit            hold;
        logic [AW-1:0] hd;
        logic          hl;
        pat = 4'b1001;
        hold = 1'b0; hd = '0; hl = 1'b0;
        got_n = 0; pronto_cnt = 0; stab_err = 0; timed_out = 1'b1;
        fin_erro = 2'bxx; fin_comp = 'x;
        top_fonte_in = f; top_destino_in = d; iniciar_in = 1'b1;
        tick();
        iniciar_in = 1'b0;
        for (int k = 0; k < 200; k++) begin
            caminho_ready_in = toggle ? pat[k % 4] : 1'b1;
            if (hold && (caminho_valid_out !== 1'b1 || caminho_data_out !== hd ||
                         caminho_last_out !== hl)) stab_err++;
            hold = caminho_valid_out && !caminho_ready_in;
            hd = caminho_data_out; hl = caminho_last_out;
            if (caminho_valid_out && caminho_ready_in && got_n < 16) begin
                got_data[got_n] = caminho_data_out;
                got_last[got_n] = caminho_last_out;
                got_n++;
            end
            if (pronto_out) begin
                pronto_cnt++;
                fin_erro = erro_out; fin_comp = comprimento_out;
                timed_out = 1'b0;
                break;
            end
            tick();
        end
        caminho_ready_in = 1'b0;
        if (!timed_out) begin
            tick();
            if (pronto_out) pronto_cnt++;
        end
        checks++;
        if (timed_out) begin
            failures++;
            $display("FAIL run_timeout: fonte=%0d destino=%0d no pronto within bound", f, d);
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (3) tick();
        checks++;
        if ({caminho_valid_out, caminho_last_out, busy_out, pronto_out} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ctrl: valid/last/busy/pronto=%b required=0000",
                     {caminho_valid_out, caminho_last_out, busy_out, pronto_out});
        end
        checks++;
        if ({caminho_data_out, erro_out, comprimento_out} !== '0) begin
            failures++;
            $display("FAIL reset_data: data=%0d erro=%0d comp=%0d required all 0",
                     caminho_data_out, erro_out, comprimento_out);
        end
        rst_n = 1'b1;
        tick();
        do_clear();
    endtask

    task automatic test_basic();
        write_pred(4'd5, 4'd3);
        write_pred(4'd3, 4'd1);
        run_path(4'd1, 4'd5, 1'b0);
        checks++;
        if (got_n !== 3 || {got_data[0], got_data[1], got_data[2]} !== {4'd5, 4'd3, 4'd1}) begin
            failures++;
            $display("FAIL basic_stream: n=%0d nodes=%0d,%0d,%0d required n=3 5,3,1",
                     got_n, got_data[0], got_data[1], got_data[2]);
        end
        checks++;
        if ({got_last[0], got_last[1], got_last[2]} !== 3'b001) begin
            failures++;
            $display("FAIL basic_last: last=%b required=001", {got_last[0], got_last[1], got_last[2]});
        end
        checks++;
        if (fin_erro !== ERRO_OK || fin_comp !== 3'd3 || pronto_cnt !== 1) begin
            failures++;
            $display("FAIL basic_status: erro=%0d comp=%0d pronto=%0d required 0 3 1",
                     fin_erro, fin_comp, pronto_cnt);
        end
    endtask

    task automatic test_backpressure();
        run_path(4'd1, 4'd5, 1'b1);
        checks++;
        if (stab_err !== 0) begin
            failures++;
            $display("FAIL bp_stable: unstable stalled cycles=%0d required=0", stab_err);
        end
        checks++;
        if (got_n !== 3 || {got_data[0], got_data[1], got_data[2]} !== {4'd5, 4'd3, 4'd1} ||
            {got_last[0], got_last[1], got_last[2]} !== 3'b001) begin
            failures++;
            $display("FAIL bp_stream: n=%0d nodes=%0d,%0d,%0d required n=3 5,3,1",
                     got_n, got_data[0], got_data[1], got_data[2]);
        end
        checks++;
        if (fin_erro !== ERRO_OK || fin_comp !== 3'd3) begin
            failures++;
            $display("FAIL bp_status: erro=%0d comp=%0d required 0 3", fin_erro, fin_comp);
        end
    endtask

    task automatic test_unreachable();
        do_clear();
        write_pred(4'd7, 4'd2);
        run_path(4'd0, 4'd7, 1'b0);
        checks++;
        if (got_n !== 2 || {got_data[0], got_data[1]} !== {4'd7, 4'd2} ||
            {got_last[0], got_last[1]} !== 2'b00) begin
            failures++;
            $display("FAIL unreach_stream: n=%0d nodes=%0d,%0d last=%b%b required n=2 7,2 last=00",
                     got_n, got_data[0], got_data[1], got_last[0], got_last[1]);
        end
        checks++;
        if (fin_erro !== ERRO_INALCANCAVEL || fin_comp !== 3'd2 || pronto_cnt !== 1) begin
            failures++;
            $display("FAIL unreach_status: erro=%0d comp=%0d pronto=%0d required 1 2 1",
                     fin_erro, fin_comp, pronto_cnt);
        end
    endtask

    task automatic test_cycle_guard();
        write_pred(4'd2, 4'd3);
        write_pred(4'd3, 4'd2);
        run_path(4'd9, 4'd2, 1'b0);
        checks++;
        if (got_n !== 4 || {got_data[0], got_data[1], got_data[2], got_data[3]} !==
                           {4'd2, 4'd3, 4'd2, 4'd3}) begin
            failures++;
            $display("FAIL guard_stream: n=%0d nodes=%0d,%0d,%0d,%0d required n=4 2,3,2,3",
                     got_n, got_data[0], got_data[1], got_data[2], got_data[3]);
        end
        checks++;
        if (fin_erro !== ERRO_LONGO || fin_comp !== 3'd4) begin
            failures++;
            $display("FAIL guard_status: erro=%0d comp=%0d required 2 4", fin_erro, fin_comp);
        end
    endtask

    task automatic test_single_node();
        run_path(4'd6, 4'd6, 1'b0);
        checks++;
        if (got_n !== 1 || got_data[0] !== 4'd6 || got_last[0] !== 1'b1) begin
            failures++;
            $display("FAIL single_stream: n=%0d node=%0d last=%b required n=1 6 last=1",
                     got_n, got_data[0], got_last[0]);
        end
        checks++;
        if (fin_erro !== ERRO_OK || fin_comp !== 3'd1) begin
            failures++;
            $display("FAIL single_status: erro=%0d comp=%0d required 0 1", fin_erro, fin_comp);
        end
    endtask

    task automatic test_clear_priority();
        int  busy_cnt;
        bit  seen;
        busy_cnt = 0; seen = 1'b0;
        top_fonte_in = 4'd1; top_destino_in = 4'd5;
        limpar_in = 1'b1; iniciar_in = 1'b1;
        tick();
        limpar_in = 1'b0; iniciar_in = 1'b0;
        for (int k = 0; k < 60 && !seen; k++) begin
            if (pronto_out) seen = 1'b1;
            else begin
                if (busy_out) busy_cnt++;
                tick();
            end
        end
        checks++;
        if (seen !== 1'b1 || busy_cnt !== 16) begin
            failures++;
            $display("FAIL clear_len: pronto=%0b busy cycles=%0d required 1 16", seen, busy_cnt);
        end
        checks++;
        if (erro_out !== ERRO_OK || comprimento_out !== 3'd0) begin
            failures++;
            $display("FAIL clear_status: erro=%0d comp=%0d required 0 0", erro_out, comprimento_out);
        end
        tick();
        run_path(4'd1, 4'd5, 1'b0);
        checks++;
        if (got_n !== 1 || got_data[0] !== 4'd5 || fin_erro !== ERRO_INALCANCAVEL) begin
            failures++;
            $display("FAIL clear_effect: n=%0d node=%0d erro=%0d required 1 5 1",
                     got_n, got_data[0], fin_erro);
        end
    endtask

    task automatic test_write_drop();
        bit seen;
        seen = 1'b0;
        write_pred(4'd5, 4'd3);
        write_pred(4'd3, 4'd1);
        top_fonte_in = 4'd1; top_destino_in = 4'd5; iniciar_in = 1'b1;
        tick();
        iniciar_in = 1'b0;
        for (int k = 0; k < 10 && !caminho_valid_out; k++) tick();
        write_pred(4'd5, 4'd4);
        caminho_ready_in = 1'b1;
        for (int k = 0; k < 40 && !seen; k++) begin
            if (pronto_out) seen = 1'b1;
            tick();
        end
        caminho_ready_in = 1'b0;
        checks++;
        if (seen !== 1'b1) begin
            failures++;
            $display("FAIL drop_run: pronto seen=%0b required=1", seen);
        end
        run_path(4'd1, 4'd5, 1'b0);
        checks++;
        if (got_n !== 3 || {got_data[0], got_data[1], got_data[2]} !== {4'd5, 4'd3, 4'd1} ||
            fin_erro !== ERRO_OK) begin
            failures++;
            $display("FAIL drop_ram: n=%0d nodes=%0d,%0d,%0d erro=%0d required n=3 5,3,1 erro=0",
                     got_n, got_data[0], got_data[1], got_data[2], fin_erro);
        end
    endtask

    task automatic test_reset_mid();
        int pr;
        pr = 0;
        top_fonte_in = 4'd1; top_destino_in = 4'd5; iniciar_in = 1'b1;
        tick();
        iniciar_in = 1'b0;
        for (int k = 0; k < 10 && !caminho_valid_out; k++) tick();
        checks++;
        if (caminho_valid_out !== 1'b1 || caminho_data_out !== 4'd5) begin
            failures++;
            $display("FAIL mid_emit: valid=%b data=%0d required 1 5", caminho_valid_out, caminho_data_out);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({caminho_valid_out, caminho_last_out, busy_out, pronto_out, caminho_data_out,
             erro_out, comprimento_out} !== '0) begin
            failures++;
            $display("FAIL mid_reset: valid=%b busy=%b data=%0d erro=%0d comp=%0d required all 0",
                     caminho_valid_out, busy_out, caminho_data_out, erro_out, comprimento_out);
        end
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (pronto_out || busy_out) pr++;
            tick();
        end
        checks++;
        if (pr !== 0) begin
            failures++;
            $display("FAIL mid_no_pronto: pronto/busy cycles=%0d required=0", pr);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_unreachable();
        test_cycle_guard();
        test_single_node();
        test_clear_priority();
        test_write_drop();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gerenciador_caminho_param.md
Name: gerenciador_caminho_param

Overview:
- Parametrised predecessor-memory manager for the shortest-path datapath.
- The solver writes each node's predecessor into an internal RAM. On a start request, the block walks the chain from destination back to source.
- Each node is emitted on a valid/ready stream, destination first and source last.
- Over the previous generation it adds: a bulk-clear mode, explicit busy/done/error status, backpressure, a path-length guard and an unreachable-node check.

Parameters:
- ADDR_WIDTH, 10: node index width; RAM depth is 2**ADDR_WIDTH.
- MAX_PATH_LEN, 2**ADDR_WIDTH: maximum number of nodes emitted before aborting with an error.
- INVALID_NODE, {ADDR_WIDTH{1'b1}}: sentinel meaning "no predecessor". This index is never a real node.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous reset, active low.
- write_en_in  in  1  predecessor write strobe from solver.
- write_addr_in  in  ADDR_WIDTH  node being written.
- write_data_in  in  ADDR_WIDTH  predecessor of write_addr_in.
- limpar_in  in  1  pulse: fill the whole RAM with INVALID_NODE.
- iniciar_in  in  1  pulse: start path reconstruction.
- top_fonte_in  in  ADDR_WIDTH  source node, sampled on accepted iniciar_in.
- top_destino_in  in  ADDR_WIDTH  destination node, sampled on accepted iniciar_in.
- caminho_data_out  out  ADDR_WIDTH  current path node.
- caminho_valid_out  out  1  node valid.
- caminho_last_out  out  1  node is the source; qualified by valid.
- caminho_ready_in  in  1  consumer ready.
- busy_out  out  1  high in every state except IDLE.
- pronto_out  out  1  one-cycle pulse when reconstruction ends, whether OK or error.
- erro_out  out  2  0 = OK, 1 = unreachable, 2 = too long. Held until the next accepted iniciar_in or limpar_in.
- comprimento_out  out  clog2(MAX_PATH_LEN+1)  nodes emitted in the last run. Held like erro_out.

Behaviour:
- Reset (asynchronous, active low) forces the following, regardless of current state:
  - state IDLE;
  - busy_out, pronto_out, caminho_valid_out and caminho_last_out all 0;
  - caminho_data_out, erro_out and comprimento_out all 0.
  - RAM contents are not reset. A reset mid-operation aborts with no pronto pulse.
- RAM: dual-port, synchronous read with 1-cycle latency, read enable tied high.
- Solver writes are accepted only in IDLE. Writes arriving in any other state are dropped.
- FSM states: IDLE, LIMPAR, LER, ESPERA, EMITIR, FIM.
- IDLE:
  - limpar_in has priority over iniciar_in when both are asserted in the same cycle.
  - limpar_in: clear the sweep counter, reset erro_out and comprimento_out to 0, go to LIMPAR.
  - iniciar_in (without limpar_in): latch fonte and destino, set cur = destino and contador = 0, reset erro_out and comprimento_out to 0, go to LER.
- LIMPAR:
  - Write INVALID_NODE to address sweep_cnt, one address per cycle.
  - After address 2**ADDR_WIDTH-1 is written, go to FIM with erro_out = 0.
  - Sweep takes exactly 2**ADDR_WIDTH cycles.
- LER: drive read_addr = cur, go to ESPERA.
- ESPERA: capture pred_r = RAM output, go to EMITIR.
- EMITIR:
  - Drive caminho_valid_out = 1 and caminho_data_out = cur.
  - Drive caminho_last_out = (cur == fonte).
  - Outputs hold stable until caminho_ready_in is high.
  - On handshake, comprimento_out increments by 1, then:
    - if cur == fonte: go to FIM, erro_out = 0;
    - else if pred_r == INVALID_NODE: go to FIM, erro_out = 1. The last emitted node has last = 0; the consumer treats erro_out != 0 as a discarded path;
    - else if contador == MAX_PATH_LEN-1: go to FIM, erro_out = 2 (cycle guard);
    - else: cur = pred_r, contador++, go to LER.
- FIM: pronto_out = 1 for exactly this cycle, then return to IDLE.
- Boundary conditions:
  - fonte == destino: exactly one node is emitted, with last = 1.
  - iniciar_in or limpar_in outside IDLE: ignored, no queuing.
  - Throughput: at most 1 node per 3 cycles with ready held high.
  - comprimento_out saturates at MAX_PATH_LEN and never wraps.
- No combinational path from caminho_ready_in to any output.

Decomposition:
- Shared package holds: FSM state encoding (3 bits), erro codes ERRO_OK/ERRO_INALCANCAVEL/ERRO_LONGO, and the clog2 helper function.
- One sub-module: the existing dual_port_ram, instantiated with DATA_WIDTH = ADDR_WIDTH and ADDR_WIDTH = ADDR_WIDTH.
- Write-port mux: the solver port in IDLE, the clear sweep in LIMPAR. Lives in this module.

Test Plan:
- ADDR_WIDTH=4, write pred[5]=3, pred[3]=1, iniciar fonte=1 destino=5, ready high -> stream 5,3,1 with last only on 1; pronto pulse; erro=0; comprimento=3.
- Same setup, ready toggling 1-0-0-1 -> data, valid and last stable while ready is low; identical sequence 5,3,1 delivered.
- limpar, then write pred[7]=2 only, iniciar fonte=0 destino=7 -> stream 7,2; erro=1; comprimento=2; pronto pulse.
- ADDR_WIDTH=4, MAX_PATH_LEN=4, cycle pred[2]=3, pred[3]=2, iniciar fonte=9 destino=2 -> exactly 4 nodes 2,3,2,3; erro=2.
- fonte=destino=6 -> single node 6 with last=1; erro=0; comprimento=1. Then limpar plus iniciar in the same cycle -> clear wins, busy for 16 cycles, pronto pulse.
- Solver write during EMITIR is dropped (RAM unchanged on re-read); rst_n asserted mid-EMITIR -> all outputs 0 immediately, busy_out=0, no pronto pulse.
